hsv_core_ctrlstatus_regfile: RTL and testbench

Responder end of the core's CSR register bus. It accepts single read or write requests from the ctrlstatus execution unit, decodes the CSR number, and answers each accepted request with a one-cycle ack and an error flag. It holds the machine-mode CSR state (mscratch, mtvec, mepc, mcause, counters) and takes side-band trap and retire updates from commit.

---
 rtl/hsv_core_ctrlstatus_regfile_if.sv | 33 +++
 rtl/hsv_core_ctrlstatus_regfile.sv | 187 ++++++++++++++++++
 tb/tb_hsv_core_ctrlstatus_regfile.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hsv_core_ctrlstatus_regfile_if.sv
`default_nettype none
// ============================================================================
// Module  : hsv_core_ctrlstatus_regfile_if
// Brief   : CSR register bus between the ctrlstatus unit and the CSR file.
// Revision: 1.0
// ============================================================================
interface hsv_core_ctrlstatus_regfile_if;
  logic        regs_req;
  logic        regs_req_is_wr;
  logic [15:0] regs_addr;
  logic [31:0] regs_wr_data;
  logic [31:0] regs_wr_biten;
  logic        regs_req_stall_rd;
  logic        regs_req_stall_wr;
  logic        regs_rd_ack;
  logic        regs_rd_err;
  logic [31:0] regs_rd_data;
  logic        regs_wr_ack;
  logic        regs_wr_err;

  modport master (
    output regs_req, regs_req_is_wr, regs_addr, regs_wr_data, regs_wr_biten,
    input  regs_req_stall_rd, regs_req_stall_wr, regs_rd_ack, regs_rd_err,
           regs_rd_data, regs_wr_ack, regs_wr_err
  );

  modport slave (
    input  regs_req, regs_req_is_wr, regs_addr, regs_wr_data, regs_wr_biten,
    output regs_req_stall_rd, regs_req_stall_wr, regs_rd_ack, regs_rd_err,
           regs_rd_data, regs_wr_ack, regs_wr_err
  );
endinterface
`default_nettype wire

// File: rtl/hsv_core_ctrlstatus_regfile.sv
`default_nettype none
// ============================================================================
// Module  : hsv_core_ctrlstatus_regfile
// Brief   : Machine-mode CSR file answering the CSR register bus, with trap
//           and retire side-band updates from commit. Define
//           HSV_CORE_CTRLSTATUS_COUNTERS_EN to build mcycle/minstret.
// Revision: 1.0
// ============================================================================
module hsv_core_ctrlstatus_regfile #(
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic                                clk_core,
  input  logic                                rst_core_n,
  hsv_core_ctrlstatus_regfile_if.slave        regs,
  input  logic                                retire,
  input  logic                                trap_valid,
  input  logic [31:0]                         trap_pc,
  input  logic [31:0]                         trap_cause
);

  localparam logic [31:0] c_MISA_VALUE    = 32'h4000_0100;
  localparam logic [11:0] c_CSR_MISA      = 12'h301;
  localparam logic [11:0] c_CSR_MTVEC     = 12'h305;
  localparam logic [11:0] c_CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] c_CSR_MEPC      = 12'h341;
  localparam logic [11:0] c_CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] c_CSR_MHARTID   = 12'hF14;
  localparam logic [11:0] c_CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] c_CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] c_CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] c_CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] c_CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] c_CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] c_CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] c_CSR_INSTRETH  = 12'hC82;

  logic        r_pending;
  logic        r_rd_ack;
  logic        r_rd_err;
  logic [31:0] r_rd_data;
  logic        r_wr_ack;
  logic        r_wr_err;
  logic [31:0] r_mscratch;
  logic [31:0] r_mtvec;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;

  logic [11:0] w_csr_num;
  logic        w_addr_ok;
  logic        w_csr_hit;
  logic        w_csr_ro;
  logic [31:0] w_csr_val;
  logic [31:0] w_wr_merged;
  logic        w_rd_accept;
  logic        w_wr_accept;
  logic        w_wr_fail;
  logic        w_wr_do;
  logic        w_wr_mtvec;
  logic        w_wr_mscratch;
  logic        w_wr_mepc;
  logic        w_wr_mcause;

  assign w_csr_num   = regs.regs_addr[15:4];
  assign w_addr_ok   = (regs.regs_addr[3:0] == 4'd0);
  assign w_csr_ro    = (w_csr_num[11:10] == 2'b11);
  assign w_rd_accept = regs.regs_req & ~regs.regs_req_is_wr & ~r_pending;
  assign w_wr_accept = regs.regs_req &  regs.regs_req_is_wr & ~r_pending;

`ifdef HSV_CORE_CTRLSTATUS_COUNTERS_EN
  logic [63:0] r_mcycle;
  logic [63:0] r_minstret;
  logic        w_wr_mcycle_lo;
  logic        w_wr_mcycle_hi;
  logic        w_wr_minstret_lo;
  logic        w_wr_minstret_hi;
`else
  logic        w_unused_retire;
  assign w_unused_retire = retire;
`endif

  // Current value of the addressed CSR; doubles as the read-modify-write base.
  always_comb begin
    w_csr_hit = 1'b1;
    w_csr_val = 32'd0;
    case (w_csr_num)
      c_CSR_MISA:      w_csr_val = c_MISA_VALUE;
      c_CSR_MHARTID:   w_csr_val = HART_ID;
      c_CSR_MTVEC:     w_csr_val = r_mtvec;
      c_CSR_MSCRATCH:  w_csr_val = r_mscratch;
      c_CSR_MEPC:      w_csr_val = r_mepc;
      c_CSR_MCAUSE:    w_csr_val = r_mcause;
`ifdef HSV_CORE_CTRLSTATUS_COUNTERS_EN
      c_CSR_MCYCLE,    c_CSR_CYCLE:    w_csr_val = r_mcycle[31:0];
      c_CSR_MCYCLEH,   c_CSR_CYCLEH:   w_csr_val = r_mcycle[63:32];
      c_CSR_MINSTRET,  c_CSR_INSTRET:  w_csr_val = r_minstret[31:0];
      c_CSR_MINSTRETH, c_CSR_INSTRETH: w_csr_val = r_minstret[63:32];
`endif
      default:         w_csr_hit = 1'b0;
    endcase
    if (!w_addr_ok) begin
      w_csr_hit = 1'b0;
      w_csr_val = 32'd0;
    end
  end

  // misa is a hit and not in the read-only space, so its writes succeed silently.
  assign w_wr_fail     = ~w_csr_hit | w_csr_ro;
  assign w_wr_do       = w_wr_accept & ~w_wr_fail;
  assign w_wr_merged   = (w_csr_val & ~regs.regs_wr_biten) |
                         (regs.regs_wr_data & regs.regs_wr_biten);
  assign w_wr_mtvec    = w_wr_do & (w_csr_num == c_CSR_MTVEC);
  assign w_wr_mscratch = w_wr_do & (w_csr_num == c_CSR_MSCRATCH);
  assign w_wr_mepc     = w_wr_do & (w_csr_num == c_CSR_MEPC);
  assign w_wr_mcause   = w_wr_do & (w_csr_num == c_CSR_MCAUSE);

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      r_pending <= 1'b0;
      r_rd_ack  <= 1'b0;
      r_rd_err  <= 1'b0;
      r_rd_data <= 32'd0;
      r_wr_ack  <= 1'b0;
      r_wr_err  <= 1'b0;
    end else begin
      r_pending <= w_rd_accept | w_wr_accept;
      r_rd_ack  <= w_rd_accept;
      r_rd_err  <= w_rd_accept & ~w_csr_hit;
      r_rd_data <= (w_rd_accept & w_csr_hit) ? w_csr_val : 32'd0;
      r_wr_ack  <= w_wr_accept;
      r_wr_err  <= w_wr_accept & w_wr_fail;
    end
  end

  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      r_mscratch <= 32'd0;
      r_mtvec    <= MTVEC_RESET & ~32'd3;
      r_mepc     <= 32'd0;
      r_mcause   <= 32'd0;
    end else begin
      if (w_wr_mscratch) r_mscratch <= w_wr_merged;
      if (w_wr_mtvec)    r_mtvec    <= w_wr_merged & ~32'd3;
      // A trap owns mepc/mcause this cycle; a colliding bus write is dropped.
      if (trap_valid) begin
        r_mepc   <= trap_pc & ~32'd3;
        r_mcause <= trap_cause;
      end else begin
        if (w_wr_mepc)   r_mepc   <= w_wr_merged & ~32'd3;
        if (w_wr_mcause) r_mcause <= w_wr_merged;
      end
    end
  end

`ifdef HSV_CORE_CTRLSTATUS_COUNTERS_EN
  assign w_wr_mcycle_lo   = w_wr_do & (w_csr_num == c_CSR_MCYCLE);
  assign w_wr_mcycle_hi   = w_wr_do & (w_csr_num == c_CSR_MCYCLEH);
  assign w_wr_minstret_lo = w_wr_do & (w_csr_num == c_CSR_MINSTRET);
  assign w_wr_minstret_hi = w_wr_do & (w_csr_num == c_CSR_MINSTRETH);

  // A half-write freezes the whole 64-bit counter for that cycle.
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      r_mcycle   <= 64'd0;
      r_minstret <= 64'd0;
    end else begin
      if (w_wr_mcycle_lo)      r_mcycle[31:0]  <= w_wr_merged;
      else if (w_wr_mcycle_hi) r_mcycle[63:32] <= w_wr_merged;
      else                     r_mcycle        <= r_mcycle + 64'd1;

      if (w_wr_minstret_lo)      r_minstret[31:0]  <= w_wr_merged;
      else if (w_wr_minstret_hi) r_minstret[63:32] <= w_wr_merged;
      else if (retire)           r_minstret        <= r_minstret + 64'd1;
    end
  end
`endif

  assign regs.regs_req_stall_rd = r_pending;
  assign regs.regs_req_stall_wr = r_pending;
  assign regs.regs_rd_ack       = r_rd_ack;
  assign regs.regs_rd_err       = r_rd_err;
  assign regs.regs_rd_data      = r_rd_data;
  assign regs.regs_wr_ack       = r_wr_ack;
  assign regs.regs_wr_err       = r_wr_err;

endmodule
`default_nettype wire

// File: tb/tb_hsv_core_ctrlstatus_regfile.sv
`default_nettype none
// ============================================================================
// Module  : tb_hsv_core_ctrlstatus_regfile
// Brief   : Directed vector bench for the CSR file; also covers the
//           HSV_CORE_CTRLSTATUS_COUNTERS_EN build when that macro is defined.
// Revision: 1.0
// ============================================================================
module tb_hsv_core_ctrlstatus_regfile;

  localparam logic [31:0] c_HART       = 32'h0000_0005;
  localparam logic [31:0] c_MTVEC_INIT = 32'h8000_0003;

  typedef struct {
    string       name;
    logic        wr;
    logic [15:0] addr;
    logic [31:0] data;
    logic [31:0] biten;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  logic        clk_core = 1'b0;
  logic        rst_core_n;
  logic        retire;
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic [31:0] trap_cause;

  int n_checks = 0;
  int n_errors = 0;

  hsv_core_ctrlstatus_regfile_if regs_if ();

  hsv_core_ctrlstatus_regfile #(
    .HART_ID     (c_HART),
    .MTVEC_RESET (c_MTVEC_INIT)
  ) dut (
    .clk_core   (clk_core),
    .rst_core_n (rst_core_n),
    .regs       (regs_if),
    .retire     (retire),
    .trap_valid (trap_valid),
    .trap_pc    (trap_pc),
    .trap_cause (trap_cause)
  );

  always #5 clk_core = ~clk_core;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus transaction: drive at negedge, wait (bounded) for no stall,
  // accept at posedge, then sample the response cycle and the cycle after.
  task automatic do_req(input logic wr, input logic [15:0] addr, input logic [31:0] data,
                        input logic [31:0] biten, input logic trap_en,
                        input logic [31:0] tpc, input logic [31:0] tcause,
                        output logic [1:0] ack, output logic err,
                        output logic [31:0] rdata, output logic [1:0] stall,
                        output logic [1:0] ack_next);
    int waits;
    waits = 0;
    @(negedge clk_core);
    regs_if.regs_req       = 1'b1;
    regs_if.regs_req_is_wr = wr;
    regs_if.regs_addr      = addr;
    regs_if.regs_wr_data   = data;
    regs_if.regs_wr_biten  = biten;
    while ((wr ? regs_if.regs_req_stall_wr : regs_if.regs_req_stall_rd) && waits < 8) begin
      @(negedge clk_core);
      waits++;
    end
    if (waits >= 8) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout: stall still %b after %0d cycles, required 0", 1'b1, waits);
    end
    trap_valid = trap_en;
    trap_pc    = tpc;
    trap_cause = tcause;
    @(posedge clk_core);
    #1;
    regs_if.regs_req = 1'b0;
    trap_valid       = 1'b0;
    @(negedge clk_core);
    ack   = {regs_if.regs_rd_ack, regs_if.regs_wr_ack};
    err   = wr ? regs_if.regs_wr_err : regs_if.regs_rd_err;
    rdata = regs_if.regs_rd_data;
    stall = {regs_if.regs_req_stall_rd, regs_if.regs_req_stall_wr};
    @(negedge clk_core);
    ack_next = {regs_if.regs_rd_ack, regs_if.regs_wr_ack};
  endtask

  task automatic run_vec(input vec_t v, input logic trap_en, input logic [31:0] tpc,
                         input logic [31:0] tcause);
    logic [1:0]  ack;
    logic        err;
    logic [31:0] rdata;
    logic [1:0]  stall;
    logic [1:0]  ack_next;
    do_req(v.wr, v.addr, v.data, v.biten, trap_en, tpc, tcause,
           ack, err, rdata, stall, ack_next);
    check({v.name, "_ack"}, {30'd0, ack}, {30'd0, ~v.wr, v.wr});
    check({v.name, "_err"}, {31'd0, err}, {31'd0, v.exp_err});
    if (!v.wr) check({v.name, "_rdata"}, rdata, v.exp_rdata);
    check({v.name, "_stall"}, {30'd0, stall}, 32'd3);
    check({v.name, "_ack_drop"}, {30'd0, ack_next}, 32'd0);
  endtask

  task automatic rd(input string name, input logic [15:0] addr, input logic [31:0] exp,
                    input logic exp_err);
    vec_t v;
    v = '{name, 1'b0, addr, 32'd0, 32'd0, exp_err, exp};
    run_vec(v, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic wr(input string name, input logic [15:0] addr, input logic [31:0] data,
                    input logic exp_err);
    vec_t v;
    v = '{name, 1'b1, addr, data, 32'hFFFF_FFFF, exp_err, 32'd0};
    run_vec(v, 1'b0, 32'd0, 32'd0);
  endtask

  function automatic logic [31:0] outs_flat();
    return {25'd0, regs_if.regs_req_stall_rd, regs_if.regs_req_stall_wr,
            regs_if.regs_rd_ack, regs_if.regs_rd_err, regs_if.regs_wr_ack,
            regs_if.regs_wr_err, |regs_if.regs_rd_data};
  endfunction

  initial begin
    vec_t vecs[$];
    vec_t trap_v;

    vecs.push_back('{"mtvec_reset",   1'b0, 16'h3050, 32'h0,         32'h0,         1'b0, 32'h8000_0000});
    vecs.push_back('{"mscr_wr_be",    1'b1, 16'h3400, 32'hFFFF_FFFF, 32'h0000_FF00, 1'b0, 32'h0});
    vecs.push_back('{"mscr_rd1",      1'b0, 16'h3400, 32'h0,         32'h0,         1'b0, 32'h0000_FF00});
    vecs.push_back('{"mscr_wr_hi",    1'b1, 16'h3400, 32'h1234_5678, 32'hFFFF_0000, 1'b0, 32'h0});
    vecs.push_back('{"mscr_rd2",      1'b0, 16'h3400, 32'h0,         32'h0,         1'b0, 32'h1234_FF00});
    vecs.push_back('{"mscr_wr_nobe",  1'b1, 16'h3400, 32'hAAAA_AAAA, 32'h0,         1'b0, 32'h0});
    vecs.push_back('{"mscr_rd3",      1'b0, 16'h3400, 32'h0,         32'h0,         1'b0, 32'h1234_FF00});
    vecs.push_back('{"mhartid_wr",    1'b1, 16'hF140, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0});
    vecs.push_back('{"mhartid_rd",    1'b0, 16'hF140, 32'h0,         32'h0,         1'b0, c_HART});
    vecs.push_back('{"bad_nibble_rd", 1'b0, 16'h3405, 32'h0,         32'h0,         1'b1, 32'h0});
    vecs.push_back('{"unimpl_rd",     1'b0, 16'h7C00, 32'h0,         32'h0,         1'b1, 32'h0});
    vecs.push_back('{"misa_rd",       1'b0, 16'h3010, 32'h0,         32'h0,         1'b0, 32'h4000_0100});
    vecs.push_back('{"misa_wr",       1'b1, 16'h3010, 32'h0,         32'hFFFF_FFFF, 1'b0, 32'h0});
    vecs.push_back('{"misa_rd2",      1'b0, 16'h3010, 32'h0,         32'h0,         1'b0, 32'h4000_0100});
    vecs.push_back('{"mtvec_wr",      1'b1, 16'h3050, 32'h1234_5677, 32'hFFFF_FFFF, 1'b0, 32'h0});
    vecs.push_back('{"mtvec_rd",      1'b0, 16'h3050, 32'h0,         32'h0,         1'b0, 32'h1234_5674});
    vecs.push_back('{"mtvec_wr_lo",   1'b1, 16'h3050, 32'hFFFF_FFFF, 32'h0000_000F, 1'b0, 32'h0});
    vecs.push_back('{"mtvec_rd2",     1'b0, 16'h3050, 32'h0,         32'h0,         1'b0, 32'h1234_567C});
    vecs.push_back('{"mcause_wr",     1'b1, 16'h3420, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0, 32'h0});
    vecs.push_back('{"mcause_rd",     1'b0, 16'h3420, 32'h0,         32'h0,         1'b0, 32'hDEAD_BEEF});
    vecs.push_back('{"bad_nibble_wr", 1'b1, 16'h3405, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0});
    vecs.push_back('{"mepc_reset",    1'b0, 16'h3410, 32'h0,         32'h0,         1'b0, 32'h0});
    vecs.push_back('{"ro_space_wr",   1'b1, 16'hC000, 32'h1,         32'hFFFF_FFFF, 1'b1, 32'h0});
    vecs.push_back('{"mepc_wr",       1'b1, 16'h3410, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0});
    vecs.push_back('{"mepc_rd",       1'b0, 16'h3410, 32'h0,         32'h0,         1'b0, 32'hFFFF_FFFC});

    regs_if.regs_req       = 1'b0;
    regs_if.regs_req_is_wr = 1'b0;
    regs_if.regs_addr      = 16'd0;
    regs_if.regs_wr_data   = 32'd0;
    regs_if.regs_wr_biten  = 32'd0;
    retire     = 1'b0;
    trap_valid = 1'b0;
    trap_pc    = 32'd0;
    trap_cause = 32'd0;
    rst_core_n = 1'b0;

    repeat (3) @(negedge clk_core);
    check("outs_in_reset", outs_flat(), 32'd0);
    rst_core_n = 1'b1;
    @(negedge clk_core);
    check("outs_after_reset", outs_flat(), 32'd0);

    foreach (vecs[i]) run_vec(vecs[i], 1'b0, 32'd0, 32'd0);

    // Trap collides with a bus write to mepc: write acks cleanly, trap wins.
    trap_v = '{"trap_vs_wr", 1'b1, 16'h3410, 32'h5555_5555, 32'hFFFF_FFFF, 1'b0, 32'h0};
    run_vec(trap_v, 1'b1, 32'h0000_1237, 32'h8000_000B);
    rd("trap_mepc",   16'h3410, 32'h0000_1234, 1'b0);
    rd("trap_mcause", 16'h3420, 32'h8000_000B, 1'b0);

    // Reset asserted right after an accept drops the response.
    @(negedge clk_core);
    regs_if.regs_req       = 1'b1;
    regs_if.regs_req_is_wr = 1'b0;
    regs_if.regs_addr      = 16'h3400;
    @(posedge clk_core);
    #1;
    regs_if.regs_req = 1'b0;
    rst_core_n       = 1'b0;
    #1;
    check("midrst_ack_cleared", outs_flat(), 32'd0);
    @(negedge clk_core);
    rst_core_n = 1'b1;
    @(negedge clk_core);
    check("midrst_no_ack", outs_flat(), 32'd0);
    rd("midrst_mscratch", 16'h3400, 32'h0, 1'b0);
    rd("midrst_mtvec",    16'h3050, 32'h8000_0000, 1'b0);

`ifdef HSV_CORE_CTRLSTATUS_COUNTERS_EN
    wr("mcycleh_wr", 16'hB800, 32'hFFFF_FFFF, 1'b0);
    wr("mcycle_wr",  16'hB000, 32'hFFFF_FFFF, 1'b0);
    rd("mcycleh_wrap", 16'hB800, 32'h0, 1'b0);
    rd("cycleh_alias", 16'hC800, 32'h0, 1'b0);
    rd("minstret_0",   16'hB020, 32'h0, 1'b0);
    @(negedge clk_core);
    retire = 1'b1;
    repeat (10) @(negedge clk_core);
    retire = 1'b0;
    rd("minstret_10",  16'hB020, 32'd10, 1'b0);
    rd("instret_alias",16'hC020, 32'd10, 1'b0);
    rd("minstreth_0",  16'hB820, 32'd0, 1'b0);
    wr("cycle_ro_wr",  16'hC000, 32'h1, 1'b1);
    wr("minstret_wr",  16'hB020, 32'd100, 1'b0);
    rd("minstret_100", 16'hB020, 32'd100, 1'b0);
`else
    @(negedge clk_core);
    retire = 1'b1;
    repeat (3) @(negedge clk_core);
    retire = 1'b0;
    rd("mcycle_absent",    16'hB000, 32'h0, 1'b1);
    rd("minstret_absent",  16'hB020, 32'h0, 1'b1);
    rd("cycleh_absent",    16'hC800, 32'h0, 1'b1);
    wr("mcycle_absent_wr", 16'hB000, 32'h1, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
